// File: rtl/or3_req_arbiter.sv
// or3_req_arbiter: round-robin arbiter for three synchronized switch requests
// with bounded hold time, timeout pulse and a registered OR of all requests.
module or3_req_arbiter #(
  parameter int HOLD_MAX    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       grant_valid,
  output logic       any_req,
  output logic       timeout,
  output logic [7:0] hold_cnt
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] req_s, grant_q, grant_d;
  logic [1:0] last_q, last_d, own, n1, n2, pick;
  logic [7:0] hold_q, hold_d;
  logic       gv_q, any_q, to_q, to_d, others;
  assign req_s  = sync_q[SYNC_STAGES-1];
  assign own    = grant_q[1] ? 2'd1 : grant_q[2] ? 2'd2 : 2'd0;
  assign n1     = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
  assign n2     = last_q == 2'd0 ? 2'd2 : last_q - 2'd1;
  assign pick   = req_s[n1] ? n1 : req_s[n2] ? n2 : last_q;
  assign others = |(req_s & ~grant_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
      state_q <= IDLE;
      grant_q <= 3'b000;
      gv_q    <= 1'b0;
      any_q   <= 1'b0;
      to_q    <= 1'b0;
      hold_q  <= 8'd0;
      last_q  <= 2'd2;
    end else begin
      sync_q[0] <= req;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= |grant_d;
      any_q   <= |req_s;
      to_q    <= to_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end
  // Every exit from GRANT goes through IDLE, giving the mandatory dead cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    last_d  = last_q;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      if (|req_s) begin
        state_d = GRANT;
        grant_d = 3'b001 << pick;
        hold_d  = 8'd1;
      end
    end else if (!req_s[own]) begin
      state_d = IDLE;
      grant_d = 3'b000;
      hold_d  = 8'd0;
      last_d  = own;
    end else if (hold_q == 8'(HOLD_MAX)) begin
      if (others) begin
        state_d = IDLE;
        grant_d = 3'b000;
        hold_d  = 8'd0;
        last_d  = own;
        to_d    = 1'b1;
      end
    end else begin
      hold_d = hold_q + 8'd1;
    end
  end
  always_comb begin
    grant       = grant_q;
    grant_valid = gv_q;
    any_req     = any_q;
    timeout     = to_q;
    hold_cnt    = hold_q;
  end
endmodule

// File: doc/or3_req_arbiter.md
Name: or3_req_arbiter

Overview:
Round-robin arbiter that shares one output channel (LED driver) between three switch-driven requesters a, b and c. The block synchronizes the asynchronous switch inputs and grants exactly one requester at a time, with a bounded hold time. It also provides a registered OR of all requests, the clocked counterpart of the or3 datapath. It sits between the switch inputs and the shared indicator or consumer.

Parameters:
HOLD_MAX, 8, maximum grant cycles while another requester waits; legal range 1..255
SYNC_STAGES, 2, synchronizer flop depth per request input; legal range 2..3

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  3  raw requests; bit0=a, bit1=b, bit2=c; asynchronous to clk
grant  output  3  one-hot grant; 000 = no owner
grant_valid  output  1  high when grant is nonzero
any_req  output  1  registered OR of synchronized requests
timeout  output  1  one-cycle pulse when a grant is pre-empted by HOLD_MAX
hold_cnt  output  8  cycles the current owner has held the grant; 0 in IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): all synchronizer flops=0, grant=000, grant_valid=0, any_req=0, timeout=0, hold_cnt=0, state=IDLE, last pointer=2, so a has first priority.
- Synchronizer: req passes through SYNC_STAGES flops to form req_s. All decisions use req_s only.
- any_req: registered OR of req_s, valid one cycle after req_s.
- Latency: a raw request edge reaches req_s after SYNC_STAGES cycles. The grant appears 1 cycle later. With the default parameters, grant follows the req edge by 3 clk edges.
- Rotation order from last pointer L: (L+1)%3, then (L+2)%3, then L.
- FSM states:
  - IDLE: grant=000 and hold_cnt=0. If req_s is nonzero, grant the first set bit in rotation order, load hold_cnt=1 and move to GRANT. Otherwise stay in IDLE.
  - GRANT, owner released: if req_s[owner]=0, clear grant to 000, set last=owner, set hold_cnt=0 and move to IDLE. A new grant needs at least one dead cycle in IDLE.
  - GRANT, pre-emption: if req_s[owner]=1, hold_cnt=HOLD_MAX and another req_s bit is set, clear grant, set last=owner, pulse timeout for 1 cycle and move to IDLE.
  - GRANT, saturation: if req_s[owner]=1, hold_cnt=HOLD_MAX and no other request is pending, keep the grant and hold hold_cnt at HOLD_MAX.
  - GRANT, otherwise: hold_cnt increments by 1.
- Simultaneous requests in IDLE: rotation order decides the owner; the other requests stay pending, with no loss.
- Owner drops in the same cycle its hold reaches HOLD_MAX: treat as a release. timeout stays 0.
- grant is always one-hot or zero and never changes owner without passing through IDLE.
- grant_valid = |grant, registered together with grant.
- Reset asserted mid-grant: grant clears immediately without waiting for a clock edge. After reset release, arbitration restarts with a first.
- Glitches on req shorter than one clk period may be missed; this is acceptable.

Test Plan:
- Reset release with req=000 -> grant=000, any_req=0, hold_cnt=0 for 10 cycles.
- Apply req=111 from reset, hold it -> grant=001 at cycle 3, timeout at hold_cnt=8, then 010 after one dead cycle, then 100, then 001, strictly rotating.
- Apply req=010 only, hold 20 cycles -> grant=010, hold_cnt saturates at 8, timeout stays 0, grant held throughout.
- req=001 granted, drop a after 4 cycles while b is pending -> grant 000 for one cycle, then 010. timeout=0 and hold_cnt restarts at 1.
- Pulse rst_n low mid-grant (grant=100) between clock edges -> grant, hold_cnt and any_req go to 0 asynchronously. With req=111 after reset release, the first grant is 001.
- Apply req=101 simultaneously with last=0 (after a previous a grant) -> grant=100 first, then 001 after release or timeout. any_req=1 throughout.
